// File: rtl/bsk_prm_pkg.sv
// Shared constants, enums and word helpers for the BskPRM host-side bus sequencer.
package bsk_prm_pkg;

    localparam logic [1:0]  REG_COM_LO  = 2'b00;
    localparam logic [1:0]  REG_COM_HI  = 2'b01;
    localparam logic [1:0]  REG_IND     = 2'b10;
    localparam logic [1:0]  REG_CTRL    = 2'b11;
    localparam logic [15:0] UNLOCK_WORD = 16'h00E1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } cyc_state_e;

    typedef enum logic [2:0] {
        STEP_UNLOCK = 3'd0,
        STEP_COM_LO = 3'd1,
        STEP_COM_HI = 3'd2,
        STEP_IND    = 3'd3,
        STEP_RD_COM = 3'd4,
        STEP_RD_ID  = 3'd5
    } step_e;

    // The board rejects command bytes that are not sent alongside their complement.
    function automatic logic [15:0] com_word(input logic [7:0] cmd_byte);
        return {~cmd_byte, cmd_byte};
    endfunction

    function automatic logic id_ok(input logic [15:0] word,
                                   input logic [7:0]  password,
                                   input logic [5:0]  version);
        return (word[15:8] == password) && (word[7:2] == version) && (word[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/bsk_prm_host_seq_if.sv
// Board-side parallel bus of one BskPRM relay-command board.
interface bsk_prm_host_seq_if;
    logic [3:0]  oCS;
    logic [1:0]  oA;
    logic        oRd;
    logic        oWr;
    logic [15:0] oD;
    logic        oDOe;
    logic [15:0] iD;

    modport master (output oCS, oA, oRd, oWr, oD, oDOe, input iD);
    modport slave  (input oCS, oA, oRd, oWr, oD, oDOe, output iD);
endinterface

// File: rtl/bsk_prm_bus_cycle.sv
// One timed read or write cycle on the board bus; a request seen in GAP chains
// straight into the next SETUP so back-to-back cycles leave a single idle clock.
module bsk_prm_bus_cycle
    import bsk_prm_pkg::*;
#(
    parameter logic [3:0]  CS       = 4'b0111,
    parameter int unsigned T_SETUP  = 32'd2,
    parameter int unsigned T_STROBE = 32'd4,
    parameter int unsigned T_HOLD   = 32'd2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [1:0]                addr_i,
    input  logic [15:0]               wdata_i,
    output logic                      gap_o,
    output logic [15:0]               rdata_o,
    bsk_prm_host_seq_if.master        bus
);

    cyc_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  cs_q, cs_d;
    logic [1:0]  a_q, a_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] d_q, d_d;
    logic        doe_q, doe_d;
    logic        we_q, we_d;
    logic [15:0] rdata_q, rdata_d;

    // Cycle state and bus pin registers; reset releases the strobes without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cs_q    <= ~CS;
            a_q     <= 2'b00;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            d_q     <= 16'h0000;
            doe_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            a_q     <= a_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            d_q     <= d_d;
            doe_q   <= doe_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and next-pin logic for the SETUP/STROBE/HOLD/GAP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        a_d     = a_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        d_d     = d_q;
        doe_d   = doe_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (req_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = 8'(T_SETUP - 32'd1);
                    cs_d    = CS;
                    a_d     = addr_i;
                    d_d     = wdata_i;
                    doe_d   = we_i;
                    we_d    = we_i;
                end else begin
                    state_d = ST_IDLE;
                    cs_d    = ~CS;
                    doe_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = 8'(T_STROBE - 32'd1);
                    rd_d    = we_q;
                    wr_d    = ~we_q;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLD;
                    cnt_d   = 8'(T_HOLD - 32'd1);
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                    if (!we_q) begin
                        rdata_d = bus.iD;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_GAP;
                    cs_d    = ~CS;
                    doe_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = ~CS;
                rd_d    = 1'b1;
                wr_d    = 1'b1;
                doe_d   = 1'b0;
            end
        endcase
    end

    assign gap_o    = (state_q == ST_GAP);
    assign rdata_o  = rdata_q;
    assign bus.oCS  = cs_q;
    assign bus.oA   = a_q;
    assign bus.oRd  = rd_q;
    assign bus.oWr  = wr_q;
    assign bus.oD   = d_q;
    assign bus.oDOe = doe_q;

endmodule

// File: rtl/bsk_prm_host_seq.sv
// Host-side sequencer: runs unlock, command, indication, readback and identity
// cycles on request or on an idle refresh timeout.
module bsk_prm_host_seq
    import bsk_prm_pkg::*;
#(
    parameter logic [3:0]  CS          = 4'b0111,
    parameter logic [7:0]  PASSWORD    = 8'hA6,
    parameter logic [5:0]  VERSION     = 6'h24,
    parameter int unsigned T_SETUP     = 32'd2,
    parameter int unsigned T_STROBE    = 32'd4,
    parameter int unsigned T_HOLD      = 32'd2,
    parameter logic [31:0] REFRESH_CYC = 32'd50000
) (
    input  logic               iClk,
    input  logic               iRes,
    input  logic [15:0]        iCmd,
    input  logic [15:0]        iInd,
    input  logic               iStart,
    output logic               oBusy,
    output logic               oDone,
    output logic               oFault,
    output logic [15:0]        oComT,
    bsk_prm_host_seq_if.master bus
);

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [15:0] comt_q, comt_d;
    step_e       step_q, step_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] ind_q, ind_d;
    logic [31:0] rtmr_q, rtmr_d;

    step_e       nxt_step_s;
    logic        cyc_req_s;
    logic        cyc_we_s;
    logic [1:0]  cyc_addr_s;
    logic [15:0] cyc_wdata_s;
    logic        cyc_gap_s;
    logic [15:0] cyc_rdata_s;
    logic [32:0] rtmr_inc_s;
    logic        expire_s;
    logic        start_s;

    // The idle clock being counted now is included, so a run begins after exactly REFRESH_CYC idle clocks.
    assign rtmr_inc_s = {1'b0, rtmr_q} + 33'd1;
    assign expire_s   = (REFRESH_CYC != 32'd0) && (rtmr_inc_s >= {1'b0, REFRESH_CYC});
    assign start_s    = ~busy_q & (iStart | expire_s);

    // Sequencer, latch and status registers.
    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            comt_q  <= 16'h0000;
            step_q  <= STEP_UNLOCK;
            cmd_q   <= 16'h0000;
            ind_q   <= 16'h0000;
            rtmr_q  <= 32'd0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            comt_q  <= comt_d;
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            ind_q   <= ind_d;
            rtmr_q  <= rtmr_d;
        end
    end

    // Step sequencing, refresh timer and readback handling.
    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        fault_d    = fault_q;
        comt_d     = comt_q;
        step_d     = step_q;
        cmd_d      = cmd_q;
        ind_d      = ind_q;
        rtmr_d     = rtmr_q;
        cyc_req_s  = 1'b0;
        nxt_step_s = step_q;
        if (!busy_q) begin
            if (start_s) begin
                busy_d     = 1'b1;
                step_d     = STEP_UNLOCK;
                cmd_d      = iCmd;
                ind_d      = iInd;
                rtmr_d     = 32'd0;
                cyc_req_s  = 1'b1;
                nxt_step_s = STEP_UNLOCK;
            end else if (REFRESH_CYC == 32'd0) begin
                rtmr_d = 32'd0;
            end else if (rtmr_q < REFRESH_CYC) begin
                rtmr_d = rtmr_q + 32'd1;
            end else begin
                rtmr_d = rtmr_q;
            end
        end else if (cyc_gap_s) begin
            if (step_q == STEP_RD_COM) begin
                comt_d = cyc_rdata_s;
            end else begin
                comt_d = comt_q;
            end
            if (step_q == STEP_RD_ID) begin
                fault_d = ~id_ok(cyc_rdata_s, PASSWORD, VERSION);
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                step_d     = step_e'(step_q + 3'd1);
                cyc_req_s  = 1'b1;
                nxt_step_s = step_e'(step_q + 3'd1);
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // Address, direction and write data of the cycle about to be launched.
    always_comb begin
        cyc_we_s    = 1'b0;
        cyc_addr_s  = REG_COM_LO;
        cyc_wdata_s = 16'h0000;
        case (nxt_step_s)
            STEP_UNLOCK: begin
                cyc_we_s    = 1'b1;
                cyc_addr_s  = REG_CTRL;
                cyc_wdata_s = UNLOCK_WORD;
            end
            STEP_COM_LO: begin
                cyc_we_s    = 1'b1;
                cyc_addr_s  = REG_COM_LO;
                cyc_wdata_s = com_word(cmd_q[7:0]);
            end
            STEP_COM_HI: begin
                cyc_we_s    = 1'b1;
                cyc_addr_s  = REG_COM_HI;
                cyc_wdata_s = com_word(cmd_q[15:8]);
            end
            STEP_IND: begin
                cyc_we_s    = 1'b1;
                cyc_addr_s  = REG_IND;
                cyc_wdata_s = ind_q;
            end
            STEP_RD_COM: begin
                cyc_we_s    = 1'b0;
                cyc_addr_s  = REG_COM_LO;
                cyc_wdata_s = 16'h0000;
            end
            STEP_RD_ID: begin
                cyc_we_s    = 1'b0;
                cyc_addr_s  = REG_CTRL;
                cyc_wdata_s = 16'h0000;
            end
            default: begin
                cyc_we_s    = 1'b0;
                cyc_addr_s  = REG_COM_LO;
                cyc_wdata_s = 16'h0000;
            end
        endcase
    end

    bsk_prm_bus_cycle #(
        .CS       (CS),
        .T_SETUP  (T_SETUP),
        .T_STROBE (T_STROBE),
        .T_HOLD   (T_HOLD)
    ) u_cycle (
        .clk     (iClk),
        .rst_n   (iRes),
        .req_i   (cyc_req_s),
        .we_i    (cyc_we_s),
        .addr_i  (cyc_addr_s),
        .wdata_i (cyc_wdata_s),
        .gap_o   (cyc_gap_s),
        .rdata_o (cyc_rdata_s),
        .bus     (bus)
    );

    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oFault = fault_q;
    assign oComT  = comt_q;

endmodule
